// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
// Used by mem_arbiter and mem_arb_timeout.
package mem_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int PORT_I = 0;
   localparam int PORT_D = 1;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_LINE_W  = 256;
   localparam int DEF_TIMEOUT = 64;

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Busy-cycle watchdog for the memory arbiter: expires in the TIMEOUT-th
// busy cycle without ack and sets a sticky error flag. TIMEOUT=0 disables it.
module mem_arb_timeout
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk_i,
   input  logic busy,
   input  logic ack,
   input  logic clear,
   output logic expire,
   output logic err
);

   generate
      if (TIMEOUT > 0) begin : g_timer
         localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

         logic [CW-1:0] count;

         // count holds the number of ack-less busy cycles already elapsed
         assign expire = busy & ~ack & (count == LAST);

         always_ff @(posedge clk_i) begin
            if (clear || !busy || ack || expire) begin
               count <= '0;
            end else begin
               count <= count + 1'b1;
            end
         end

         always_ff @(posedge clk_i) begin
            if (clear) begin
               err <= 1'b0;
            end else if (expire) begin
               err <= 1'b1;
            end
         end
      end else begin : g_none
         logic unused_in;
         assign unused_in = ^{clk_i, busy, ack, clear};
         assign expire    = 1'b0;
         assign err       = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one cache-line memory port between I-cache (port 0)
// and D-cache (port 1). Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate on ties.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int LINE_W  = DEF_LINE_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p0_enable_i,
   input  logic              p0_write_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [LINE_W-1:0] p0_data_i,
   output logic [LINE_W-1:0] p0_data_o,
   output logic              p0_ack_o,
   input  logic              p1_enable_i,
   input  logic              p1_write_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [LINE_W-1:0] p1_data_i,
   output logic [LINE_W-1:0] p1_data_o,
   output logic              p1_ack_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [1:0]        grant_o,
   output logic              err_o
);

   arb_state_t        state;
   logic              pick;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [LINE_W-1:0] sel_data;
   logic              expire;
   logic              done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_grant;
`endif

   always_comb begin
      pick = p1_enable_i;
      if (p0_enable_i && p1_enable_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         pick = ~last_grant;
`else
         pick = 1'(PORT_D);
`endif
      end
      sel_write = pick ? p1_write_i : p0_write_i;
      sel_addr  = pick ? p1_addr_i  : p0_addr_i;
      sel_data  = pick ? p1_data_i  : p0_data_i;
   end

   mem_arb_timeout #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk_i  (clk_i),
      .busy   (state == BUSY),
      .ack    (mem_ack_i),
      .clear  (rst_i),
      .expire (expire),
      .err    (err_o)
   );

   // grant_o is zero outside BUSY, so it alone qualifies the port acks
   assign done      = (mem_ack_i | expire) & ~rst_i;
   assign p0_ack_o  = grant_o[PORT_I] & done;
   assign p1_ack_o  = grant_o[PORT_D] & done;
   assign p0_data_o = mem_data_i;
   assign p1_data_o = mem_data_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         grant_o      <= '0;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_grant   <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (p0_enable_i || p1_enable_i) begin
                  state        <= BUSY;
                  grant_o      <= port_onehot(pick);
                  mem_enable_o <= 1'b1;
                  mem_write_o  <= sel_write;
                  mem_addr_o   <= sel_addr;
                  mem_data_o   <= sel_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_grant   <= pick;
`endif
               end
            end
            BUSY: begin
               if (mem_ack_i || expire) begin
                  state        <= IDLE;
                  grant_o      <= '0;
                  mem_enable_o <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle
// plus literal expectations for latency, priority, freeze, timeout and reset.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;
   localparam int TO = 64;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
   logic [AW-1:0] p0_addr_i, p1_addr_i;
   logic [LW-1:0] p0_data_i, p1_data_i, p0_data_o, p1_data_o;
   logic          p0_ack_o, p1_ack_o;
   logic          mem_enable_o, mem_write_o, mem_ack_i, err_o;
   logic [AW-1:0] mem_addr_o;
   logic [LW-1:0] mem_data_o, mem_data_i;
   logic [1:0]    grant_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic mon_on = 1'b0;

   mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
      .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
      .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
      .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .grant_o(grant_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   int            m_owner = -1;   // -1: nobody holds the memory
   int            m_age   = 0;    // busy cycles already spent without ack
   int            m_last  = 1;
   int            m_pick;
   logic          m_err   = 1'b0;
   logic          m_wr;
   logic [AW-1:0] m_addr;
   logic [LW-1:0] m_data;

   function automatic logic m_expire();
      return (m_owner >= 0) && !mem_ack_i && (m_age + 1 == TO);
   endfunction

   function automatic int m_choose();
      if (p0_enable_i && p1_enable_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         return (m_last == 1) ? 0 : 1;
`else
         return 1;
`endif
      end
      return p1_enable_i ? 1 : 0;
   endfunction

   always @(posedge clk_i) begin
      if (rst_i) begin
         m_owner = -1; m_age = 0; m_err = 1'b0; m_last = 1;
      end else if (m_owner < 0) begin
         if (p0_enable_i || p1_enable_i) begin
            m_pick  = m_choose();
            m_owner = m_pick;
            m_last  = m_pick;
            m_age   = 0;
            m_wr    = m_pick == 1 ? p1_write_i : p0_write_i;
            m_addr  = m_pick == 1 ? p1_addr_i  : p0_addr_i;
            m_data  = m_pick == 1 ? p1_data_i  : p0_data_i;
         end
      end else if (mem_ack_i || m_expire()) begin
         if (!mem_ack_i) m_err = 1'b1;
         m_owner = -1;
      end else begin
         m_age++;
      end
   end

   always @(negedge clk_i) begin : mon
      logic [1:0] eg;
      logic       fin;
      if (mon_on) begin
         eg  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
         fin = (mem_ack_i || m_expire()) && !rst_i;
         chk("grant", grant_o, eg);
         chk("mem_enable", mem_enable_o, m_owner >= 0);
         chk("p0_ack", p0_ack_o, m_owner == 0 && fin);
         chk("p1_ack", p1_ack_o, m_owner == 1 && fin);
         chk("err", err_o, m_err);
         chk("p0_data", p0_data_o, mem_data_i);
         chk("p1_data", p1_data_o, mem_data_i);
         if (m_owner >= 0) begin
            chk("mem_write", mem_write_o, m_wr);
            chk("mem_addr", mem_addr_o, m_addr);
            chk("mem_data", mem_data_o, m_data);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Acts as memory (acks in busy cycle delay+1, never if delay<0) and as the
   // requester that drops enable in the cycle after its ack.
   task automatic serve(input int delay, input logic [LW-1:0] rdata,
                        output int port, output int cycles, output logic [LW-1:0] seen);
      int n = 0;
      port = -1; cycles = 0; seen = '0;
      while (!mem_enable_o && n < 20) begin tick(); n++; end
      if (!mem_enable_o) begin
         chk("serve_start_timeout", 1'b0, 1'b1);
         return;
      end
      for (int k = 0; k < 200; k++) begin
         cycles++;
         if (delay >= 0 && cycles > delay) begin
            mem_ack_i  = 1'b1;
            mem_data_i = rdata;
         end
         #1;
         if (p0_ack_o) port = 0;
         else if (p1_ack_o) port = 1;
         if (port >= 0) begin
            seen = (port == 1) ? p1_data_o : p0_data_o;
            tick();
            mem_ack_i = 1'b0;
            if (port == 0) p0_enable_i = 1'b0;
            else           p1_enable_i = 1'b0;
            return;
         end
         tick();
      end
      chk("serve_ack_timeout", 1'b0, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no-finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int port, cyc;
      logic [LW-1:0] seen;
      logic [LW-1:0] a5, beef;
      int order[$];
      a5   = {32{8'hA5}};
      beef = {8{32'hDEAD_BEEF}};

      rst_i = 1'b1;
      p0_enable_i = 1'b0; p0_write_i = 1'b0; p0_addr_i = '0; p0_data_i = '0;
      p1_enable_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
      mem_ack_i = 1'b0; mem_data_i = '0;
      repeat (3) tick();
      rst_i  = 1'b0;
      mon_on = 1'b1;

      chk("rst_grant", grant_o, 2'b00);
      chk("rst_mem_enable", mem_enable_o, 1'b0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_err", err_o, 1'b0);
      tick();

      // single p0 read, memory acks after 10 cycles
      p0_enable_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h0000_0400;
      tick();
      chk("t1_latency_enable", mem_enable_o, 1'b1);
      chk("t1_addr", mem_addr_o, 32'h400);
      chk("t1_write", mem_write_o, 1'b0);
      serve(10, a5, port, cyc, seen);
      chk("t1_owner", port, 0);
      chk("t1_busy_cycles", cyc, 11);
      chk("t1_read_data", seen, a5);
      tick();

      // simultaneous: p0 read 0x300, p1 write 0x800
      p0_enable_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h300;
      p1_enable_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h800; p1_data_i = beef;
      tick();
      chk("t2_first_grant", grant_o, 2'b10);
      chk("t2_mem_write", mem_write_o, 1'b1);
      chk("t2_mem_data", mem_data_o, beef);
      serve(3, '0, port, cyc, seen);
      chk("t2_first_owner", port, 1);
      chk("t2_gap_idle", mem_enable_o, 1'b0);
      tick();
      chk("t2_second_grant", grant_o, 2'b01);
      serve(2, a5, port, cyc, seen);
      chk("t2_second_owner", port, 0);
      tick();

      // repeated simultaneous requests: grants alternate p1, p0
      for (int r = 0; r < 4; r++) begin
         p0_enable_i = 1'b1; p0_addr_i = 32'h1000 + r;
         p1_enable_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h2000 + r;
         tick();
         serve(r, '0, port, cyc, seen); order.push_back(port);
         tick();
         serve(1, '0, port, cyc, seen); order.push_back(port);
         tick();
      end
      foreach (order[i]) chk("t3_grant_order", order[i], (i % 2 == 0) ? 1 : 0);

      // p1 served alone, then a tie: round robin hands the tie to p0
      p1_enable_i = 1'b1; p1_addr_i = 32'hA00;
      tick();
      serve(1, '0, port, cyc, seen);
      tick();
      p0_enable_i = 1'b1; p0_addr_i = 32'hB00;
      p1_enable_i = 1'b1; p1_addr_i = 32'hC00;
      tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("t3_tie_after_p1", grant_o, 2'b01);
`else
      chk("t3_tie_after_p1", grant_o, 2'b10);
`endif
      serve(0, '0, port, cyc, seen);
      tick();
      serve(0, '0, port, cyc, seen);
      tick();

      // requester changes address mid-transaction
      p0_enable_i = 1'b1; p0_addr_i = 32'h400;
      tick(); tick(); tick();
      p0_addr_i = 32'h500;
      tick();
      chk("t4_addr_frozen", mem_addr_o, 32'h400);
      serve(2, a5, port, cyc, seen);
      chk("t4_owner", port, 0);
      tick();

      // memory never acks
      p0_enable_i = 1'b1; p0_addr_i = 32'h600;
      tick();
      serve(-1, '0, port, cyc, seen);
      chk("t5_timeout_owner", port, 0);
      chk("t5_timeout_cycle", cyc, 64);
      chk("t5_err_set", err_o, 1'b1);
      mem_ack_i = 1'b1;
      #1;
      chk("t5_late_ack_p0", p0_ack_o, 1'b0);
      chk("t5_late_ack_p1", p1_ack_o, 1'b0);
      tick();
      mem_ack_i = 1'b0;
      tick();
      chk("t5_err_sticky", err_o, 1'b1);
      chk("t5_idle_grant", grant_o, 2'b00);

      // reset in the 5th busy cycle
      p1_enable_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'hC00; p1_data_i = beef;
      tick();
      repeat (4) tick();
      rst_i = 1'b1; p1_enable_i = 1'b0;
      #1;
      chk("t6_no_ack_p1", p1_ack_o, 1'b0);
      tick();
      rst_i = 1'b0;
      chk("t6_rst_grant", grant_o, 2'b00);
      chk("t6_rst_enable", mem_enable_o, 1'b0);
      chk("t6_rst_write", mem_write_o, 1'b0);
      chk("t6_rst_addr", mem_addr_o, 32'h0);
      chk("t6_rst_data", mem_data_o, 256'h0);
      chk("t6_rst_err", err_o, 1'b0);
      p0_enable_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h900;
      tick();
      chk("t6_new_addr", mem_addr_o, 32'h900);
      serve(1, a5, port, cyc, seen);
      chk("t6_new_owner", port, 0);
      chk("t6_new_data", seen, a5);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
